serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 179 +++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial adder with IDLE/RUN/DONE controller. Computes
//                {cout, sum} = a + b + cin one bit per clock, LSB first, on a
//                single shared 1-bit full-adder slice (two half adders + OR).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1      rising-edge clock
//    reset  in   1      synchronous active-high reset
//    start  in   1      request pulse, accepted only in IDLE
//    a      in   WIDTH  operand A, sampled on the accepting edge
//    b      in   WIDTH  operand B, sampled on the accepting edge
//    cin    in   1      carry-in, sampled on the accepting edge
//    busy   out  1      high while the adder is in RUN
//    done   out  1      one-cycle completion pulse (DONE state)
//    sum    out  WIDTH  registered result
//    cout   out  1      registered carry out of bit WIDTH-1
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only ever needs to reach WIDTH-1, so ceil(log2(WIDTH)) bits
    // are sufficient and the counter never wraps while in RUN.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q,  a_sh_d;
    logic [WIDTH-1:0] b_sh_q,  b_sh_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q,  cout_d;

    // ------------------------------------------------------------------
    // Shared 1-bit full adder built from two half adders and an OR.
    // ------------------------------------------------------------------
    logic w_ha1_s;
    logic w_ha1_c;
    logic w_ha2_s;
    logic w_ha2_c;
    logic w_fa_c;

    always_comb begin
        w_ha1_s = a_sh_q[0] ^ b_sh_q[0];
        w_ha1_c = a_sh_q[0] & b_sh_q[0];
        w_ha2_s = w_ha1_s ^ carry_q;
        w_ha2_c = w_ha1_s & carry_q;
        w_fa_c  = w_ha1_c | w_ha2_c;
    end

    logic w_accept;
    logic w_last;

    always_comb begin
        w_accept = (state_q == S_IDLE) && start;
        w_last   = (state_q == S_RUN) && (cnt_q == LAST_CNT);
    end

    // ------------------------------------------------------------------
    // Process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Process 3: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
        sum  = sum_q;
        cout = cout_q;
    end

    // ------------------------------------------------------------------
    // Datapath next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        if (w_accept) begin
            // Operands are captured only here; later changes on a/b/cin
            // cannot disturb the operation in flight.
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = cin;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            // Result enters at the MSB; after WIDTH shifts bit 0 of the
            // answer has reached sum[0].
            sum_d   = {w_ha2_s, sum_q[WIDTH-1:1]};
            carry_d = w_fa_c;
            if (w_last) begin
                cout_d = w_fa_c;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Directed self-checking bench for serial_adder_ctrl (WIDTH=16)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks;
    int n_fail;

    serial_adder_ctrl #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete operation with operand scrambling during RUN.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tc, input logic [WIDTH-1:0] es, input logic ec);
        int  nb;
        bit  overlap;
        a = ta; b = tb; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        nb = 0;
        overlap = 0;
        while (busy && nb < 100) begin
            if (done) overlap = 1;
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
            nb++;
            tick();
        end
        check_val({tag, "_busy_len"}, nb, WIDTH);
        check_val({tag, "_overlap"}, {31'd0, overlap}, 32'd0);
        check_val({tag, "_done"}, {31'd0, done}, 32'd1);
        check_val({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        check_val({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        tick();
        check_val({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
        // Result must hold after completion.
        check_val({tag, "_sum_hold"}, {16'd0, sum}, {16'd0, es});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done;
        int t_done[$];
        logic [WIDTH-1:0] s_done[$];

        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Reset state
        repeat (3) tick();
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_sum",  {16'd0, sum}, 32'd0);
        check_val("rst_cout", {31'd0, cout}, 32'd0);

        // Start coincident with reset is ignored
        start = 1'b1; a = 16'h1111; b = 16'h2222;
        tick();
        reset = 1'b0; start = 1'b0;
        tick();
        check_val("rst_start_ignored", {31'd0, busy}, 32'd0);

        // Directed arithmetic vectors
        do_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        do_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        do_op("msb",     16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        do_op("allone",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        do_op("zero",    16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        do_op("cinprop", 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1);
        do_op("top",     16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);

        // Start during RUN is ignored
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        a = 16'h0001; b = 16'h0001; start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                n_done++;
                check_val("ignore_sum", {16'd0, sum}, 32'h5555);
            end
            tick();
        end
        check_val("ignore_ndone", n_done, 1);

        // Reset during the 5th RUN cycle
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check_val("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        check_val("abort_sum",  {16'd0, sum}, 32'd0);
        check_val("abort_cout", {31'd0, cout}, 32'd0);
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) n_done++;
            tick();
        end
        check_val("abort_quiet", n_done, 0);
        do_op("after_abort", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);

        // Start held high: one operation every WIDTH+2 cycles
        a = 16'd3; b = 16'd4; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) begin
                t_done.push_back(i);
                s_done.push_back(sum);
            end
        end
        start = 1'b0;
        repeat (WIDTH + 4) tick();
        check_val("b2b_ndone", t_done.size(), 2);
        if (t_done.size() >= 2) begin
            check_val("b2b_gap", t_done[1] - t_done[0], WIDTH + 2);
            check_val("b2b_sum0", {16'd0, s_done[0]}, 32'd7);
            check_val("b2b_sum1", {16'd0, s_done[1]}, 32'd7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
